// File: rtl/core_pkg.sv
// Shared core types for the memory port.
//   mem_state_t : responder FSM states
//   WORD_W      : data/address word width
//   mem_req_t   : one word request {we, addr, wdata}; the datapath side uses it as well
package core_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core control path and the memory responder.
//   req, we, addr, wdata : request side, driven by the initiator (master)
//   rdata, ready, busy   : response side, driven by the responder (slave)
//   err                  : sticky access-error flag, driven by the responder
interface mem_responder_if;
  import core_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/bram_sp.sv
// Single-port synchronous block RAM, inferred.
//   clk_i   : clock
//   en_i    : port enable; the read register only updates when enabled
//   we_i    : write enable (qualified by en_i)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, one cycle after an enabled access; write-first
// Contents are not reset.
module bram_sp #(
  parameter int unsigned AddrW = 14,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's instruction/data port.
// Services one word request at a time: writes complete one cycle after accept, reads
// RD_LAT+1 cycles after accept. Misaligned or out-of-range accesses complete with normal
// timing, suppress the write / return zero, and set the sticky err flag.
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   bus   : slave side of mem_responder_if (req/we/addr/wdata in, rdata/ready/busy/err out)
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned RD_LAT     = 2    // legal range 1..7
) (
  input  logic            clk,
  input  logic            rstn,
  mem_responder_if.slave  bus
);
  import core_pkg::*;

  localparam int unsigned CntW = 3;

  mem_state_t              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WORD_W-1:0]       rdata_q, rdata_d;
  logic                    bad_q, bad_d;
  logic                    err_q, err_d;

  mem_req_t                in_req;
  logic                    addr_bad;
  logic                    accept;
  logic                    ram_en;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [WORD_W-1:0]       ram_rdata;

  assign in_req = '{we: bus.we, addr: bus.addr, wdata: bus.wdata};

  assign addr_bad = (in_req.addr[1:0] != 2'b00) ||
                    ((in_req.addr >> (DEPTH_LOG2 + 2)) != '0);

  assign accept   = (state_q == IDLE) && bus.req;
  // The RAM is only enabled on the accept edge, so its registered output holds the word
  // at the captured address for the whole RD_WAIT period regardless of later addr changes.
  assign ram_en   = accept && !addr_bad;
  assign ram_addr = in_req.addr[DEPTH_LOG2+1:2];

  bram_sp #(
    .AddrW (DEPTH_LOG2),
    .DataW (WORD_W)
  ) u_bram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (in_req.we),
    .addr_i  (ram_addr),
    .wdata_i (in_req.wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    bad_d   = bad_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          err_d = err_q | addr_bad;
          if (in_req.we) begin
            state_d = DONE;
          end else begin
            bad_d   = addr_bad;
            cnt_d   = CntW'(RD_LAT - 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bad_q ? '0 : ram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        // A still-high req here is the completed request, not a new one.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == DONE);
  assign bus.busy  = (state_q == RD_WAIT);
  assign bus.err   = err_q;

endmodule
